// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one request outstanding to
// instruction memory, buffers one returned word for decode, and handles redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_mem_is_ready,
  output logic [31:0] inst_mem_addr,
  input  logic        inst_mem_is_valid,
  input  logic [31:0] inst_mem_read_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc,
  output logic        exception,
  output logic [1:0]  state
);

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] TRAP  = 2'd2;

  // Handshakes: a request transfers in every cycle inst_mem_is_ready is high
  // (memory never back-pressures); a response is a one-cycle inst_mem_is_valid
  // pulse, in order; the buffer is consumed in every cycle fetch_valid && !stall.
  logic [31:0] pc;
  logic        drop;
  logic        consume;
  logic        misaligned;

  assign consume           = fetch_valid && !stall;
  assign misaligned        = (redirect_pc[1:0] != 2'b00);
  assign inst_mem_addr     = pc;
  assign inst_mem_is_ready = reset && (state == ISSUE) && (!fetch_valid || !stall) && !redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET;
      drop        <= 1'b0;
      state       <= ISSUE;
      fetch_valid <= 1'b0;
      fetch_inst  <= 32'h0;
      fetch_pc    <= RESET;
      exception   <= 1'b0;
    end else begin
      if (consume) fetch_valid <= 1'b0;
      case (state)
        ISSUE: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            if (misaligned) begin
              exception <= 1'b1;
              state     <= TRAP;
            end else begin
              pc <= redirect_pc;
            end
          end else if (inst_mem_is_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            if (misaligned) begin
              exception <= 1'b1;
              state     <= TRAP;
            end else begin
              pc <= redirect_pc;
              // A response in the redirect cycle is the stale one; otherwise
              // the word still in flight must be dropped when it arrives.
              if (inst_mem_is_valid) begin
                drop  <= 1'b0;
                state <= ISSUE;
              end else begin
                drop <= 1'b1;
              end
            end
          end else if (inst_mem_is_valid) begin
            state <= ISSUE;
            if (drop) begin
              drop <= 1'b0;
            end else begin
              fetch_inst  <= inst_mem_read_data;
              fetch_pc    <= pc;
              fetch_valid <= 1'b1;
              pc          <= pc + 32'd4;
            end
          end
        end
        TRAP: begin
          fetch_valid <= 1'b0;
        end
        default: begin
          state <= ISSUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a latency-programmable memory model, request/fetch
// scoreboards and directed scenarios for stall, redirect, trap and PC wrap.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_mem_is_ready;
  logic [31:0] inst_mem_addr;
  logic        inst_mem_is_valid;
  logic [31:0] inst_mem_read_data;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        exception;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  logic [31:0] req_q[$];
  logic [31:0] exp_q[$];

  fetch_ctrl #(.RESET(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_mem_is_ready(inst_mem_is_ready),
    .inst_mem_addr(inst_mem_addr), .inst_mem_is_valid(inst_mem_is_valid),
    .inst_mem_read_data(inst_mem_read_data), .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .exception(exception),
    .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // memory model: response arrives lat cycles after the request cycle
  logic        pend;
  int          cnt;
  logic [31:0] paddr;
  assign inst_mem_is_valid  = pend && (cnt == 1);
  assign inst_mem_read_data = inst_mem_is_valid ? mem_word(paddr) : 32'h0;

  always @(posedge clk) begin
    if (!reset) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (inst_mem_is_ready) begin
      pend  <= 1'b1;
      cnt   <= lat;
      paddr <= inst_mem_addr;
    end else if (pend) begin
      if (cnt == 1) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (inst_mem_is_ready) begin
        if (req_q.size() == 0) check("req_unexpected", inst_mem_addr, 32'hFFFF_FFFF);
        else check("req_addr", inst_mem_addr, req_q.pop_front());
      end
      if (fetch_valid && !stall) begin
        if (exp_q.size() == 0) check("fetch_unexpected", fetch_pc, 32'hFFFF_FFFF);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("fetch_pc", fetch_pc, e);
          check("fetch_inst", fetch_inst, mem_word(e));
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input int l);
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    lat         = l;
    req_q.delete();
    exp_q.delete();
    step(2);
    reset = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step(1);
    redirect    = 1'b0;
  endtask

  task automatic drain(input string tag);
    check({tag, "_req_left"}, req_q.size(), 0);
    check({tag, "_fetch_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    start(1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_inst", fetch_inst, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_exception", exception, 0);
    check("rst_ready", inst_mem_is_ready, 0);
    check("rst_addr", inst_mem_addr, 0);
    check("rst_state", state, 0);

    // back-to-back fetch, 1-cycle memory
    start(1);
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_q = '{32'h0, 32'h4, 32'h8};
    step(7);
    drain("seq");

    // stall holds the buffer at pc 0x4 for 5 cycles
    start(1);
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_q = '{32'h0, 32'h4, 32'h8};
    step(4);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", fetch_valid, 1);
      check("stall_pc", fetch_pc, 32'h4);
      check("stall_inst", fetch_inst, mem_word(32'h4));
      check("stall_ready", inst_mem_is_ready, 0);
      step(1);
    end
    stall = 1'b0;
    step(3);
    drain("stall");

    // redirect while waiting on 0x8, 3-cycle memory
    start(3);
    req_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
    exp_q = '{32'h0, 32'h4, 32'h100};
    step(9);
    pulse_redirect(32'h100);
    step(7);
    drain("redir_wait");

    // redirect in the same cycle the 0x8 response arrives
    start(3);
    req_q = '{32'h0, 32'h4, 32'h8, 32'h200, 32'h204};
    exp_q = '{32'h0, 32'h4, 32'h200};
    step(11);
    @(negedge clk);
    check("resp_same_cycle", inst_mem_is_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    check("redir_resp_no_valid", fetch_valid, 0);
    step(5);
    drain("redir_resp");

    // redirect in ISSUE: request to target next cycle
    start(1);
    req_q = '{32'h0, 32'h300, 32'h304};
    exp_q = '{32'h0, 32'h300};
    step(2);
    pulse_redirect(32'h300);
    step(3);
    drain("redir_issue");

    // misaligned redirect traps until reset
    start(1);
    req_q = '{32'h0};
    exp_q = '{32'h0};
    step(2);
    pulse_redirect(32'h102);
    @(negedge clk);
    check("trap_exception", exception, 1);
    check("trap_fetch_valid", fetch_valid, 0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        redirect    = 1'b1;
        redirect_pc = 32'h40;
      end else begin
        redirect = 1'b0;
      end
      @(negedge clk);
      check("trap_no_req", inst_mem_is_ready, 0);
      check("trap_sticky", exception, 1);
      step(1);
    end
    redirect = 1'b0;
    drain("trap");
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    req_q = '{32'h0, 32'h4};
    exp_q = '{32'h0};
    @(negedge clk);
    check("trap_cleared", exception, 0);
    step(3);
    drain("trap_restart");

    // PC wraps from 0xFFFF_FFFC to 0
    start(1);
    req_q = '{32'h0, 32'hFFFF_FFFC, 32'h0};
    exp_q = '{32'h0, 32'hFFFF_FFFC};
    step(2);
    pulse_redirect(32'hFFFF_FFFC);
    step(3);
    drain("wrap");

    reset = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
